simpleton_mem_arb: RTL and testbench

Two-port memory arbiter placed between the Simpleton datapath and the shared 256×8 memory. Addresses 0x00–0x7F are ROM; 0x80–0xFF are RAM. The arbiter lets the CPU (port 0) and a debug/loader port (port 1) share the single memory port. It grants one transfer at a time with fair round-robin, blocks writes to ROM, and returns read data one cycle after the access.

---
 rtl/simpleton_mem_arb_pkg.sv | 21 ++
 rtl/simpleton_mem_arb_arb_rr2_pit.sv | 23 ++
 rtl/simpleton_mem_arb.sv | 145 ++++++++++++++
 tb/tb_simpleton_mem_arb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/simpleton_mem_arb_pkg.sv
// Shared encodings and constants for the Simpleton memory arbiter.
package simpleton_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int unsigned RAM_SEL_BIT = 7;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    // Upper half of the address map is RAM, lower half is ROM.
    function automatic logic is_ram(input logic [7:0] addr);
        return addr[RAM_SEL_BIT];
    endfunction

endpackage

// File: rtl/simpleton_mem_arb_arb_rr2_pit.sv
// Combinational two-way round-robin pick.
module arb_rr2_pit
    import simpleton_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_port,
    output logic valid,
    output logic winner
);

    // A lone requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = ~last_port;
        end else if (req1) begin
            winner = PORT_DBG;
        end
    end

endmodule

// File: rtl/simpleton_mem_arb.sv
// Two-port round-robin arbiter in front of the shared 256x8 Simpleton memory.
module simpleton_mem_arb
    import simpleton_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata,
    output logic       err,
    output logic       cpu_stall,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_din,
    output logic       mem_write,
    input  logic [7:0] mem_dout,
    output logic [7:0] conflict_cnt
);

    state_e     state_q, state_d;
    logic       last_port_q, last_port_d;
    logic       sel_we_q, sel_we_d;
    logic [7:0] sel_addr_q, sel_addr_d;
    logic [7:0] sel_wdata_q, sel_wdata_d;
    logic       sel_port_q, sel_port_d;
    logic       rvalid0_q, rvalid0_d;
    logic       rvalid1_q, rvalid1_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic [7:0] cnt_q, cnt_d;

    logic       pick_valid;
    logic       pick_winner;

    arb_rr2_pit u_pick (
        .req0      (req0),
        .req1      (req1),
        .last_port (last_port_q),
        .valid     (pick_valid),
        .winner    (pick_winner)
    );

    // State and response registers; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_port_q <= PORT_DBG;
            sel_we_q    <= 1'b0;
            sel_addr_q  <= '0;
            sel_wdata_q <= '0;
            sel_port_q  <= PORT_CPU;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_port_q <= last_port_d;
            sel_we_q    <= sel_we_d;
            sel_addr_q  <= sel_addr_d;
            sel_wdata_q <= sel_wdata_d;
            sel_port_q  <= sel_port_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next state: latch the winner in IDLE, capture the response leaving XFER.
    always_comb begin
        state_d     = state_q;
        last_port_d = last_port_q;
        sel_we_d    = sel_we_q;
        sel_addr_d  = sel_addr_q;
        sel_wdata_d = sel_wdata_q;
        sel_port_d  = sel_port_q;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 && req1 && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (pick_valid) begin
                    state_d     = ST_XFER;
                    last_port_d = pick_winner;
                    sel_port_d  = pick_winner;
                    sel_we_d    = (pick_winner == PORT_DBG) ? we1    : we0;
                    sel_addr_d  = (pick_winner == PORT_DBG) ? addr1  : addr0;
                    sel_wdata_d = (pick_winner == PORT_DBG) ? wdata1 : wdata0;
                end
            end
            ST_XFER: begin
                state_d   = ST_IDLE;
                rvalid0_d = (sel_port_q == PORT_CPU);
                rvalid1_d = (sel_port_q == PORT_DBG);
                rdata_d   = sel_we_q ? 8'h00 : mem_dout;
                err_d     = sel_we_q & ~is_ram(sel_addr_q);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory port and grants are only active during XFER; ROM writes are suppressed.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        mem_write = 1'b0;
        if (state_q == ST_XFER) begin
            gnt0      = (sel_port_q == PORT_CPU);
            gnt1      = (sel_port_q == PORT_DBG);
            mem_addr  = sel_addr_q;
            mem_din   = sel_wdata_q;
            mem_write = sel_we_q & is_ram(sel_addr_q);
        end
    end

    assign cpu_stall    = req0 & ~gnt0;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign rdata        = rdata_q;
    assign err          = err_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_simpleton_mem_arb.sv
// Directed self-checking bench for simpleton_mem_arb with a behavioural 256x8 memory.
module tb_simpleton_mem_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, err, cpu_stall, mem_write;
    logic [7:0] rdata, mem_addr, mem_din, mem_dout, conflict_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram [128];

    always #5 clk = ~clk;

    simpleton_mem_arb dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata        (rdata),
        .err          (err),
        .cpu_stall    (cpu_stall),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_write    (mem_write),
        .mem_dout     (mem_dout),
        .conflict_cnt (conflict_cnt)
    );

    // ROM contents are a fixed pattern of the address.
    function automatic logic [7:0] rom_byte(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    // Memory model: combinational read, RAM written on the clock edge.
    always @(posedge clk) begin
        if (mem_write && mem_addr[7]) ram[mem_addr[6:0]] <= mem_din;
    end
    assign mem_dout = mem_addr[7] ? ram[mem_addr[6:0]] : rom_byte(mem_addr);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_cnt", conflict_cnt, 8'h00);

        // Single CPU read of ROM 0x05
        req0 = 1; we0 = 0; addr0 = 8'h05;
        #1;
        chk("rd_stall_idle", cpu_stall, 1);
        tick();
        chk("rd_gnt0", gnt0, 1);
        chk("rd_gnt1", gnt1, 0);
        chk("rd_mem_addr", mem_addr, 8'h05);
        chk("rd_mem_write", mem_write, 0);
        chk("rd_stall_gnt", cpu_stall, 0);
        req0 = 0;
        tick();
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rdata", rdata, 8'h5F);
        chk("rd_err", err, 0);

        // Debug write of 0xA5 to RAM 0x80
        req1 = 1; we1 = 1; addr1 = 8'h80; wdata1 = 8'hA5;
        tick();
        chk("wr_gnt1", gnt1, 1);
        chk("wr_mem_write", mem_write, 1);
        chk("wr_mem_din", mem_din, 8'hA5);
        chk("wr_mem_addr", mem_addr, 8'h80);
        req1 = 0;
        tick();
        chk("wr_rvalid1", rvalid1, 1);
        chk("wr_rdata", rdata, 8'h00);
        chk("wr_err", err, 0);
        chk("wr_idle_mem_write", mem_write, 0);
        req0 = 1; we0 = 0; addr0 = 8'h80;
        tick();
        chk("wrrb_gnt0", gnt0, 1);
        req0 = 0;
        tick();
        chk("wrrb_rvalid0", rvalid0, 1);
        chk("wrrb_rdata", rdata, 8'hA5);

        // ROM write to 0x10 is blocked
        req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'hFF;
        tick();
        chk("rom_gnt1", gnt1, 1);
        chk("rom_mem_write", mem_write, 0);
        req1 = 0;
        tick();
        chk("rom_rvalid1", rvalid1, 1);
        chk("rom_err", err, 1);
        chk("rom_rdata", rdata, 8'h00);
        chk("rom_mem_write_after", mem_write, 0);
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        req0 = 0;
        tick();
        chk("rom_rb_rvalid0", rvalid0, 1);
        chk("rom_rb_err", err, 0);
        chk("rom_rb_rdata", rdata, 8'h4A);

        // Contention from reset: grants alternate 0,1 and only IDLE cycles count
        rst = 1;
        req0 = 1; we0 = 0; addr0 = 8'h01;
        req1 = 1; we1 = 0; addr1 = 8'h81;
        tick(); tick();
        chk("cont_rst_cnt", conflict_cnt, 8'h00);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cont_gnt0_%0d", i), gnt0, ((i % 4) == 1) ? 8'd1 : 8'd0);
            chk($sformatf("cont_gnt1_%0d", i), gnt1, ((i % 4) == 3) ? 8'd1 : 8'd0);
            chk($sformatf("cont_stall_%0d", i), cpu_stall, ((i % 4) == 1) ? 8'd0 : 8'd1);
            chk($sformatf("cont_cnt_%0d", i), conflict_cnt, 8'((i + 1) / 2));
            tick();
        end
        chk("cont_cnt_final", conflict_cnt, 8'd4);

        // Saturation: keep both requesting well past 255 IDLE cycles
        for (int i = 0; i < 600; i++) tick();
        chk("sat_cnt", conflict_cnt, 8'hFF);
        tick(); tick();
        chk("sat_cnt_hold", conflict_cnt, 8'hFF);

        // Reset during the XFER of a RAM write: write lands, no response
        req0 = 0; req1 = 0;
        tick(); tick();
        req1 = 1; we1 = 1; addr1 = 8'h80; wdata1 = 8'h3C;
        tick();
        chk("mid_gnt1", gnt1, 1);
        chk("mid_mem_write", mem_write, 1);
        rst = 1; req1 = 0;
        tick();
        chk("mid_rvalid1", rvalid1, 0);
        chk("mid_rvalid0", rvalid0, 0);
        chk("mid_err", err, 0);
        chk("mid_gnt1_after", gnt1, 0);
        rst = 0;
        req0 = 1; we0 = 0; addr0 = 8'h80;
        req1 = 1; we1 = 0; addr1 = 8'h00;
        tick();
        chk("mid_tie_gnt0", gnt0, 1);
        chk("mid_tie_gnt1", gnt1, 0);
        chk("mid_tie_addr", mem_addr, 8'h80);
        req0 = 0; req1 = 0;
        tick();
        chk("mid_rb_rvalid0", rvalid0, 1);
        chk("mid_rb_rdata", rdata, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
